// File: rtl/dii_event_packetizer.sv
// dii_event_packetizer: turns one fixed-size debug event into a DII packet
// (dest, src, type/flags, WORDS payload flits) on a flat valid/ready port.
// Optional feature macro: DII_EVENT_PACKETIZER_OVERFLOW_EN. When defined, the
// producer is never stalled: events arriving while busy are dropped and
// counted, and the count is reported in the TYPE flit.
module dii_event_packetizer #(
  parameter int unsigned WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            id,
  input  logic                  event_valid,
  output logic                  event_ready,
  input  logic [9:0]            event_dest,
  input  logic [7:0]            event_type,
  input  logic [WORDS*16-1:0]   event_data,
  output logic [15:0]           out_data,
  output logic                  out_valid,
  output logic                  out_first,
  output logic                  out_last,
  input  logic                  out_ready
);

  localparam int unsigned CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned DW = WORDS * 16;
  localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DEST    = 3'd1,
    SRC     = 3'd2,
    TYPE    = 3'd3,
    PAYLOAD = 3'd4
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [7:0]      type_q;
  logic [DW-1:0]   data_q;
  logic            capture, fire, stall;
  logic            valid_next, first_next, last_next, ready_next;
  logic [15:0]     data_next;
  logic [7:0]      type_hi;

  // The destination is never re-read after flit0 leaves, so out_data itself
  // is its only holding register.
  assign capture = (state == IDLE) && event_valid && event_ready;
  assign fire    = out_valid && out_ready;
  assign stall   = out_valid && !out_ready;

`ifdef DII_EVENT_PACKETIZER_OVERFLOW_EN
  logic [6:0] drop_cnt, drop_next;
  logic       drop;

  assign drop = event_valid && (state != IDLE);

  // Saturating drop count; TYPE handshake clears it, a same-cycle drop restarts it at 1
  always_comb begin
    drop_next = drop_cnt;
    if ((state == TYPE) && fire) begin
      drop_next = drop ? 7'd1 : 7'd0;
    end else if (drop && (drop_cnt != 7'h7f)) begin
      drop_next = drop_cnt + 7'd1;
    end
  end

  // Drop counter register
  always_ff @(posedge clk) begin
    if (rst) drop_cnt <= 7'd0;
    else     drop_cnt <= drop_next;
  end

  assign type_hi    = {(drop_next != 7'd0), drop_next};
  assign ready_next = 1'b1;
`else
  assign type_hi    = 8'h00;
  assign ready_next = (state_next == IDLE);
`endif

  // Next state, word counter and registered-output values
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    valid_next = out_valid;
    first_next = out_first;
    last_next  = out_last;
    data_next  = out_data;

    unique case (state)
      IDLE:    if (capture) state_next = DEST;
      DEST:    if (fire) state_next = SRC;
      SRC:     if (fire) state_next = TYPE;
      TYPE: begin
        if (fire) begin
          state_next = PAYLOAD;
          cnt_next   = '0;
        end
      end
      PAYLOAD: begin
        if (fire) begin
          if (cnt == LAST_IDX) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Flit fields only move when the current flit is not stalled
    if (!stall) begin
      valid_next = (state_next != IDLE);
      first_next = (state_next == DEST);
      last_next  = (state_next == PAYLOAD) && (cnt_next == LAST_IDX);
      unique case (state_next)
        DEST:    data_next = {6'b0, event_dest};
        SRC:     data_next = {6'b0, id};
        TYPE:    data_next = {type_hi, type_q};
        PAYLOAD: data_next = data_q[16*int'(cnt_next) +: 16];
        default: data_next = 16'h0000;
      endcase
    end
  end

  // State, counter, captured event and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      type_q      <= 8'h00;
      data_q      <= '0;
      out_valid   <= 1'b0;
      out_first   <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= 16'h0000;
      event_ready <= 1'b1;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      out_valid   <= valid_next;
      out_first   <= first_next;
      out_last    <= last_next;
      out_data    <= data_next;
      event_ready <= ready_next;
      if (capture) begin
        type_q <= event_type;
        data_q <= event_data;
      end
    end
  end

endmodule

// File: tb/tb_dii_event_packetizer.sv
// Bench for dii_event_packetizer: directed scenarios plus random traffic,
// checked against a flit-queue model of the packet format. Honours
// DII_EVENT_PACKETIZER_OVERFLOW_EN when it is defined for the build.
module tb_dii_event_packetizer;

  localparam int unsigned W = 4;
`ifdef DII_EVENT_PACKETIZER_OVERFLOW_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, event_valid, event_ready, out_valid, out_first, out_last, out_ready;
  logic [9:0]      id, event_dest;
  logic [7:0]      event_type;
  logic [W*16-1:0] event_data;
  logic [15:0]     out_data;

  logic        b_event_valid, b_event_ready, b_out_valid, b_out_first, b_out_last, b_out_ready;
  logic [15:0] b_event_data, b_out_data;

  dii_event_packetizer #(.WORDS(W)) dut (
    .clk(clk), .rst(rst), .id(id), .event_valid(event_valid), .event_ready(event_ready),
    .event_dest(event_dest), .event_type(event_type), .event_data(event_data),
    .out_data(out_data), .out_valid(out_valid), .out_first(out_first), .out_last(out_last),
    .out_ready(out_ready)
  );

  dii_event_packetizer #(.WORDS(1)) dut1 (
    .clk(clk), .rst(rst), .id(id), .event_valid(b_event_valid), .event_ready(b_event_ready),
    .event_dest(event_dest), .event_type(event_type), .event_data(b_event_data),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_first(b_out_first), .out_last(b_out_last),
    .out_ready(b_out_ready)
  );

  // kind: 0 dest, 1 src, 2 type, 3 payload
  typedef struct {
    logic [15:0] data;
    logic        first;
    logic        last;
    int          kind;
  } flit_t;

  flit_t       q[$];
  logic [15:0] dut_flits[$];
  int          drops = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_a [7];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Queue a whole packet for the event currently on the inputs
  task automatic build_packet();
    flit_t f;
    f = '{data: {6'b0, event_dest}, first: 1'b1, last: 1'b0, kind: 0};
    q.push_back(f);
    f = '{data: {6'b0, id}, first: 1'b0, last: 1'b0, kind: 1};
    q.push_back(f);
    f = '{data: {8'h00, event_type}, first: 1'b0, last: 1'b0, kind: 2};
    q.push_back(f);
    for (int k = 0; k < int'(W); k++) begin
      f = '{data: event_data[16*k +: 16], first: 1'b0, last: (k == int'(W) - 1), kind: 3};
      q.push_back(f);
    end
  endtask

  // One clock: advance the model on the edge, then compare DUT outputs
  task automatic cycle();
    bit    busy, drop, fire, take;
    flit_t f;
    busy = (q.size() != 0);
    drop = busy && event_valid;
    fire = busy && out_ready;
    take = !busy && event_valid;
    if (out_valid && out_ready) dut_flits.push_back(out_data);
    @(posedge clk);
    if (rst) begin
      q.delete();
      drops = 0;
    end else begin
      if (fire && q[0].kind == 2) drops = drop ? 1 : 0;
      else if (drop && drops < 127) drops++;
      if (fire) begin
        void'(q.pop_front());
        if (q.size() != 0 && q[0].kind == 2) begin
          f = q[0];
          f.data[15:8] = OVF ? {(drops != 0), 7'(drops)} : 8'h00;
          q[0] = f;
        end
      end
      if (take) build_packet();
    end
    #1;
    check("out_valid", out_valid, q.size() != 0);
    check("event_ready", event_ready, OVF ? 1'b1 : (q.size() == 0));
    check("first_and_last", out_first & out_last, 1'b0);
    if (q.size() != 0) begin
      check("out_data", out_data, q[0].data);
      check("out_first", out_first, q[0].first);
      check("out_last", out_last, q[0].last);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    check("drain_timeout", q.size(), 0);
  endtask

  task automatic check_flits(input string tag);
    check({tag, "_count"}, dut_flits.size(), 7);
    for (int i = 0; i < 7 && i < dut_flits.size(); i++) check(tag, dut_flits[i], exp_a[i]);
  endtask

  task automatic offer_directed();
    id = 10'h005; event_dest = 10'h001; event_type = 8'h02;
    event_data = 64'h4444_3333_2222_1111;
    event_valid = 1'b1;
    cycle();
    event_valid = 1'b0;
  endtask

  task automatic offer_random();
    event_dest = 10'($urandom());
    event_type = 8'($urandom());
    for (int k = 0; k < int'(W); k++) event_data[16*k +: 16] = 16'($urandom());
    event_valid = 1'b1;
    cycle();
    event_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] bd[$];
    logic        bf[$];
    logic        bl[$];
    int          n;

    exp_a = '{16'h0001, 16'h0005, 16'h0002, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
    rst = 1'b1; event_valid = 1'b0; out_ready = 1'b1; id = 10'h005;
    event_dest = '0; event_type = '0; event_data = '0;
    b_event_valid = 1'b0; b_event_data = '0; b_out_ready = 1'b1;

    // Reset state
    cycle(); cycle();
    check("rst_data", out_data, 16'h0000);
    check("rst_first", out_first, 1'b0);
    check("rst_last", out_last, 1'b0);
    rst = 1'b0;
    cycle();

    // Single event, continuous ready
    dut_flits.delete();
    offer_directed();
    check("latency_flit0", {out_valid, out_first, out_data}, {2'b11, 16'h0001});
    repeat (7) cycle();
    check_flits("single");
    check("single_idle", out_valid, 1'b0);

    // Same event under random backpressure
    dut_flits.delete();
    offer_directed();
    n = 0;
    while (q.size() != 0 && n < 80) begin
      out_ready = 1'($urandom_range(0, 1));
      cycle();
      n++;
    end
    out_ready = 1'b1;
    drain(20);
    cycle();
    check_flits("backpressure");

    // Back-to-back with event_valid held high
    event_valid = 1'b1;
    event_data = 64'hAAAA_BBBB_CCCC_DDDD;
    cycle();
    drain(20);
    event_data = 64'h1234_5678_9ABC_DEF0;
    cycle();
    check("b2b_flit0", {out_valid, out_first}, 2'b11);
    event_valid = 1'b0;
    drain(20);

    // Reset during the second payload flit while stalled
    offer_random();
    n = 0;
    while (q.size() > int'(W) - 1 && n < 20) begin
      cycle();
      n++;
    end
    out_ready = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("abort_valid", out_valid, 1'b0);
    check("abort_ready", event_ready, 1'b1);
    out_ready = 1'b1;
    offer_random();
    drain(20);

`ifdef DII_EVENT_PACKETIZER_OVERFLOW_EN
    // Drops while stalled in payload are reported by the next packet
    offer_random();
    n = 0;
    while (q.size() > int'(W) - 1 && n < 20) begin
      cycle();
      n++;
    end
    out_ready = 1'b0;
    event_valid = 1'b1;
    repeat (3) cycle();
    event_valid = 1'b0;
    out_ready = 1'b1;
    drain(20);
    event_type = 8'h5A;
    event_valid = 1'b1;
    cycle();
    event_valid = 1'b0;
    cycle(); cycle();
    check("ovf_type_flit", out_data, 16'h835A);
    drain(20);
    event_valid = 1'b1;
    cycle();
    event_valid = 1'b0;
    cycle(); cycle();
    check("ovf_type_clear", out_data[15:8], 8'h00);
    drain(20);
`endif

    // WORDS=1 instance: single payload flit is last and not first
    check("w1_ready", b_event_ready, 1'b1);
    id = 10'h005; event_dest = 10'h00A; event_type = 8'h33;
    b_event_data = 16'hBEEF;
    b_event_valid = 1'b1;
    cycle();
    b_event_valid = 1'b0;
    n = 0;
    while (b_out_valid && n < 10) begin
      bd.push_back(b_out_data); bf.push_back(b_out_first); bl.push_back(b_out_last);
      cycle();
      n++;
    end
    check("w1_count", bd.size(), 4);
    if (bd.size() == 4) begin
      check("w1_dest", {bf[0], bl[0], bd[0]}, {2'b10, 16'h000A});
      check("w1_src",  {bf[1], bl[1], bd[1]}, {2'b00, 16'h0005});
      check("w1_type", {bf[2], bl[2], bd[2]}, {2'b00, 16'h0033});
      check("w1_data", {bf[3], bl[3], bd[3]}, {2'b01, 16'hBEEF});
    end

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      event_valid = ($urandom_range(0, 9) < 3);
      out_ready   = ($urandom_range(0, 9) < 7);
      if (q.size() == 0 && !event_valid) id = 10'($urandom());
      event_dest = 10'($urandom());
      event_type = 8'($urandom());
      for (int k = 0; k < int'(W); k++) event_data[16*k +: 16] = 16'($urandom());
      cycle();
    end
    event_valid = 1'b0;
    out_ready = 1'b1;
    drain(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dii_event_packetizer.md
Name: dii_event_packetizer

Overview:
- Upstream of each debug ring port: turns a debug module's fixed-size event into one DII packet and drives the ring's per-port flat local input (data/valid/first/last/ready).
- Packet: flit0 destination, flit1 source, flit2 type/flags, then WORDS payload flits.
- Holds one event at a time and respects ring backpressure flit by flit.

Parameters:
- WORDS, 4, number of 16-bit payload flits per packet (1..16).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id  in  10  this port's ring address; zero-extended into the source flit
- event_valid  in  1  event offered
- event_ready  out  1  event accepted when event_valid && event_ready
- event_dest  in  10  destination address
- event_type  in  8  event type code
- event_data  in  WORDS*16  payload; word k = bits [16k+15:16k]
- out_data  out  16  flit data
- out_valid  out  1  flit valid
- out_first  out  1  high on flit0 only
- out_last  out  1  high on final payload flit only
- out_ready  in  1  downstream accepts flit when out_valid && out_ready

Behaviour:
- Reset: clk-synchronous; rst high for one rising edge gives state IDLE, out_valid=0, out_first=0, out_last=0, out_data=0, event_ready=1, internal counters 0.
- Reset mid-packet aborts the packet: out_valid=0 the next cycle, no last flit is sent, and the captured event is discarded.
- FSM states: IDLE, DEST, SRC, TYPE, PAYLOAD.
- IDLE:
  - event_ready=1, out_valid=0.
  - On event handshake, capture dest/type/data into registers and go to DEST.
- DEST:
  - out_valid=1, out_first=1, out_data={6'b0, dest}.
  - On out_ready, go to SRC.
- SRC:
  - out_data={6'b0, id}; id is sampled live.
  - On out_ready, go to TYPE.
- TYPE:
  - out_data={8'h00, type}; see Optional Feature for bits [15:8].
  - On out_ready, go to PAYLOAD with word counter=0.
- PAYLOAD:
  - out_data = captured word[counter], least-significant word first.
  - out_last=1 when counter==WORDS-1.
  - On out_ready: if last, go to IDLE; else counter+1.
  - Counter width is clog2(WORDS), with minimum 1 bit.
- Outputs are registered/state-decoded. While out_valid && !out_ready, out_data/first/last are held stable. out_valid never drops without a handshake, except on reset.
- Latency: event handshake at edge N gives flit0 valid in cycle N+1. A packet takes WORDS+3 cycles with continuous out_ready.
- event_ready is high only in IDLE, so there is one idle bubble between back-to-back packets. Next packet's flit0 comes 1 cycle after the previous last handshake + event handshake.
- Captured event registers change only on event handshake. Input changes while busy have no effect.
- WORDS=1: the single payload flit carries both out_last=1 and out_first=0.
- out_first and out_last are never both high.

Optional Feature:
- Macro: DII_EVENT_PACKETIZER_OVERFLOW_EN.
- Enabled:
  - event_ready is constantly 1 after reset; the producer is never stalled.
  - An event_valid while not IDLE is dropped and increments a 7-bit saturating drop counter (stays at 127).
  - The TYPE flit carries bit15 = (drop counter != 0) and bits[14:8] = drop counter value at TYPE-flit emission.
  - The counter clears on the TYPE-flit handshake. If a drop occurs in that same cycle, the counter is set to 1.
  - A drop in IDLE is impossible: the event is captured.
- Disabled: TYPE bits[15:8]=0, event_ready follows the FSM as above, and no counter logic exists.

Test Plan:
- Reset then single event (WORDS=4, id=10'h005, dest=10'h001, type=8'h02, data=64'h4444_3333_2222_1111), out_ready=1. Required flits:
  - 0x0001 with first=1
  - 0x0005
  - 0x0002
  - 0x1111, 0x2222, 0x3333
  - 0x4444 with last=1
  - flit0 in cycle N+1, 7 consecutive valid cycles.
- Backpressure: out_ready toggling 1,0,0,1 pseudo-randomly → flit sequence identical to the single-event case. Data/first/last are stable on every stalled cycle, and no flit is duplicated or lost.
- Back-to-back: event_valid held high with two events → second flit0 exactly 1 cycle after the first packet's last handshake+1. event_ready=0 throughout the first packet.
- Reset asserted during the 2nd payload flit with out_ready=0 → next cycle out_valid=0 and event_ready=1. A new event then produces a complete clean packet.
- WORDS=1 build: event data 16'hBEEF → flits dest, src, type, 0xBEEF with last=1, first=0.
- With DII_EVENT_PACKETIZER_OVERFLOW_EN and out_ready=0, offer 3 extra events while busy → event_ready stays 1. The next packet's TYPE flit = {1'b1, 7'd3, type}, and the following packet's TYPE bits[15:8]=0.
